video_capture: RTL and testbench
================================

# video_capture

Receiving end of the video interface: samples the HS/VS/BLANK/RGB stream produced by the display timing generator and turns it into a coordinate-tagged pixel stream with frame framing and geometry checking. It sits on the sink side of a video link, for example in a loopback self-check path or ahead of a frame-buffer writer. It verifies that every line and frame has the expected dimensions and reports lock and error status.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame

Ports:
- pixel_clk  in  1  pixel clock; all inputs are synchronous to it
- pixel_rst  in  1  reset, asynchronous, active-high
- HS  in  1  horizontal sync, active-low
- VS  in  1  vertical sync, active-low
- BLANK  in  1  high during active (displayed) pixels, low during blanking
- RGB  in  24  pixel data, {R,G,B}
- pix_valid  out  1  pixel output qualifier
- pix_x  out  $clog2(HDISP)  column of the current pixel
- pix_y  out  $clog2(VDISP)  line of the current pixel
- pix_data  out  24  registered RGB
- sof  out  1  with pixel (0,0)
- eol  out  1  with pixel x=HDISP-1
- frame_done  out  1  one-cycle pulse when a frame has correct geometry
- line_err  out  1  one-cycle pulse when a line has the wrong length
- frame_err  out  1  one-cycle pulse when a frame has the wrong line count
- locked  out  1  high after a correct frame
- frame_cnt  out  16  count of good frames, wraps
- err_cnt  out  16  line_err plus frame_err events, saturates at 16'hFFFF

## Operation
- Stage 1 registers HS, VS, BLANK and RGB, and keeps the previous VS and BLANK values for edge detection.
- Frame start is the VS falling edge at stage 1.
- End of line is the BLANK falling edge at stage 1.
- Internal x counter, width $clog2(HDISP+1): saturates at HDISP. Internal y counter, width $clog2(VDISP+1): saturates at VDISP.
- FSM states:
  - SEARCH: reset state. All pixels are ignored. On a VS falling edge: clear x and y, go to FRAME.
  - FRAME:
    - Each active cycle (BLANK=1) with x<HDISP and y<VDISP emits a pixel (pix_valid=1, pix_x=x, pix_y=y, pix_data=RGB), then x increments.
    - Active cycles with x≥HDISP or y≥VDISP emit nothing. x still advances, saturating.
    - On a BLANK falling edge: if x≠HDISP, pulse line_err, increment err_cnt and clear locked. Then x←0 and y increments (saturating).
    - On a VS falling edge:
      - If y=VDISP: pulse frame_done, increment frame_cnt, set locked.
      - Otherwise: pulse frame_err, increment err_cnt, clear locked.
      - In both cases: x←0, y←0, stay in FRAME.
- sof = pix_valid with x=0 and y=0. eol = pix_valid with x=HDISP-1.
- Simultaneous BLANK falling edge and VS falling edge: the line closes first, so y is incremented and the line is checked. The frame check then uses the incremented y. If both errors occur, err_cnt increases by 2, saturating.
- HS is sampled only for future use. It takes no part in framing: lines are delimited by BLANK.
- Reset values: pix_valid, sof, eol, frame_done, line_err, frame_err and locked are 0. pix_x, pix_y and pix_data are 0. frame_cnt and err_cnt are 0. State is SEARCH.
- A reset assertion mid-frame takes effect immediately, with no partial pixels. After release the block returns to SEARCH and waits for the next VS falling edge.

## Timing
- Pixel latency: RGB at input cycle n appears on pix_data at cycle n+2 (stage-1 register plus output register). pix_x, pix_y, sof and eol are aligned with pix_data.
- frame_done, frame_err and line_err assert 2 cycles after the causing input edge, for exactly 1 cycle.
- locked, frame_cnt and err_cnt update in the same cycle as the pulse that causes them.
- No back-pressure: the consumer must accept one pixel per clock.
- Inter-pixel gaps within a line are legal. x advances only on active cycles.

## Test plan
1. **Nominal geometry.** HDISP=32, VDISP=24, driven by the standard timing generator for 3 frames.
   - First frame after reset: no frame_done (state SEARCH until the first VS falling edge).
   - Frames 2 and 3: 768 pix_valid each; frame_done once per frame; frame_cnt=2; locked=1; err_cnt=0.
   - pix_data equals input RGB delayed 2 cycles.
2. **Short line.** One line with 31 active pixels.
   - line_err pulses once and locked drops to 0.
   - Rows and columns of the remaining pixels stay correct.
   - The next clean frame sets locked again.
3. **Long frame.** 25 active lines.
   - 24 lines are emitted; the 25th emits no pixels.
   - frame_err pulses at the VS falling edge; err_cnt=1; frame_done stays 0.
4. **Reset mid-frame.** pixel_rst pulsed at line 10.
   - All outputs go to 0 immediately.
   - No pixels until the next VS falling edge.
   - The first full frame after that produces frame_done.
5. **Framing markers.**
   - sof is high only with pix_x=0, pix_y=0.
   - eol is high exactly 24 times per frame, each time with pix_x=31.
6. **Counter saturation.** Force err_cnt to 16'hFFFE, then inject 3 bad lines → err_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/video_capture_if.sv
// rtl/video_capture_if.sv - video sink bus: raw timing/RGB in, tagged pixel stream and status out
//
// Purpose: groups the sampled video timing inputs and the coordinate-tagged
// pixel / status outputs of video_capture into one bundle.
// Signals:
//   HS, VS (active-low), BLANK (high = active), RGB[23:0]   : from video source
//   pix_valid, pix_x, pix_y, pix_data, sof, eol             : pixel stream
//   frame_done, line_err, frame_err, locked, frame_cnt,
//   err_cnt                                                 : geometry status
// Modports: master = video source / stream consumer, slave = video_capture.
interface video_capture_if #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  logic          HS;
  logic          VS;
  logic          BLANK;
  logic [23:0]   RGB;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [23:0]   pix_data;
  logic          sof;
  logic          eol;
  logic          frame_done;
  logic          line_err;
  logic          frame_err;
  logic          locked;
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;

  modport master (
    output HS, VS, BLANK, RGB,
    input  pix_valid, pix_x, pix_y, pix_data, sof, eol,
    input  frame_done, line_err, frame_err, locked, frame_cnt, err_cnt
  );

  modport slave (
    input  HS, VS, BLANK, RGB,
    output pix_valid, pix_x, pix_y, pix_data, sof, eol,
    output frame_done, line_err, frame_err, locked, frame_cnt, err_cnt
  );
endinterface

// File: rtl/video_capture.sv
// rtl/video_capture.sv - video sink: pixel tagging, framing and geometry check
//
// Purpose: samples HS/VS/BLANK/RGB, emits a coordinate-tagged pixel stream and
// checks every line (HDISP active pixels) and frame (VDISP active lines).
// Ports:
//   pixel_clk : pixel clock
//   pixel_rst : asynchronous active-high reset
//   bus       : video_capture_if.slave (video inputs, pixel stream, status)
// Latency: input cycle n -> pixel outputs and pulses at cycle n+2.
module video_capture #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic           pixel_clk,
  input  logic           pixel_rst,
  video_capture_if.slave bus
);
  localparam int XW  = $clog2(HDISP);
  localparam int YW  = $clog2(VDISP);
  localparam int XCW = $clog2(HDISP + 1);
  localparam int YCW = $clog2(VDISP + 1);
  localparam logic [XCW-1:0] X_END  = XCW'(HDISP);
  localparam logic [XCW-1:0] X_LAST = XCW'(HDISP - 1);
  localparam logic [YCW-1:0] Y_END  = YCW'(VDISP);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_FRAME  = 1'b1;

  // stage 1
  logic          r_s1_hs;
  logic          r_s1_vs;
  logic          r_s1_vs_d;
  logic          r_s1_blank;
  logic          r_s1_blank_d;
  logic [23:0]   r_s1_rgb;

  // framing state
  logic [0:0]     r_state;
  logic [XCW-1:0] r_x;
  logic [YCW-1:0] r_y;
  // counters saturate at the nominal size; these remember that the size was
  // exceeded so a too-long line/frame is not mistaken for a correct one
  logic           r_x_over;
  logic           r_y_over;

  // output stage
  logic          r_pix_valid;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic [23:0]   r_pix_data;
  logic          r_sof;
  logic          r_eol;
  logic          r_frame_done;
  logic          r_line_err;
  logic          r_frame_err;
  logic          r_locked;
  logic [15:0]   r_frame_cnt;
  logic [15:0]   r_err_cnt;

  logic           w_vs_fall;
  logic           w_blank_fall;
  logic           w_in_frame;
  logic           w_emit;
  logic           w_line_err;
  logic           w_frame_ok;
  logic           w_frame_err;
  logic [YCW-1:0] w_y_close;
  logic           w_y_over_close;
  logic [YCW-1:0] w_frame_y;
  logic           w_frame_over;
  logic [16:0]    w_err_sum;
  logic [15:0]    w_err_next;
  logic           w_hs_unused;

  // HS is captured for future use only; framing is driven by BLANK and VS
  assign w_hs_unused = r_s1_hs;

  always_comb begin
    w_vs_fall      = r_s1_vs_d & ~r_s1_vs;
    w_blank_fall   = r_s1_blank_d & ~r_s1_blank;
    w_in_frame     = (r_state == S_FRAME);
    w_emit         = w_in_frame & r_s1_blank & (r_x < X_END) & (r_y < Y_END);
    w_line_err     = w_in_frame & w_blank_fall & ((r_x != X_END) | r_x_over);
    w_y_close      = (r_y == Y_END) ? r_y : r_y + 1'b1;
    w_y_over_close = r_y_over | (r_y == Y_END);
    // a line closing together with VS is counted before the frame is judged
    w_frame_y      = w_blank_fall ? w_y_close : r_y;
    w_frame_over   = w_blank_fall ? w_y_over_close : r_y_over;
    w_frame_ok     = w_in_frame & w_vs_fall & (w_frame_y == Y_END) & ~w_frame_over;
    w_frame_err    = w_in_frame & w_vs_fall & ~((w_frame_y == Y_END) & ~w_frame_over);
    w_err_sum      = {1'b0, r_err_cnt} + 17'(w_line_err) + 17'(w_frame_err);
    w_err_next     = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_s1_hs      <= 1'b1;
      r_s1_vs      <= 1'b1;
      r_s1_vs_d    <= 1'b1;
      r_s1_blank   <= 1'b0;
      r_s1_blank_d <= 1'b0;
      r_s1_rgb     <= '0;
      r_state      <= S_SEARCH;
      r_x          <= '0;
      r_y          <= '0;
      r_x_over     <= 1'b0;
      r_y_over     <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_data   <= '0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_s1_hs      <= bus.HS;
      r_s1_vs      <= bus.VS;
      r_s1_vs_d    <= r_s1_vs;
      r_s1_blank   <= bus.BLANK;
      r_s1_blank_d <= r_s1_blank;
      r_s1_rgb     <= bus.RGB;

      r_pix_valid  <= w_emit;
      r_sof        <= w_emit & (r_x == '0) & (r_y == '0);
      r_eol        <= w_emit & (r_x == X_LAST);
      if (w_emit) begin
        r_pix_x    <= r_x[XW-1:0];
        r_pix_y    <= r_y[YW-1:0];
        r_pix_data <= r_s1_rgb;
      end

      r_line_err   <= w_line_err;
      r_frame_err  <= w_frame_err;
      r_frame_done <= w_frame_ok;
      r_err_cnt    <= w_err_next;
      if (w_frame_ok) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_frame_ok) begin
        r_locked <= 1'b1;
      end else if (w_line_err | w_frame_err) begin
        r_locked <= 1'b0;
      end

      case (r_state)
        S_SEARCH: begin
          if (w_vs_fall) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x_over <= 1'b0;
            r_y_over <= 1'b0;
            r_state  <= S_FRAME;
          end
        end
        default: begin
          if (r_s1_blank) begin
            if (r_x != X_END) begin
              r_x <= r_x + 1'b1;
            end else begin
              r_x_over <= 1'b1;
            end
          end
          if (w_blank_fall) begin
            r_x      <= '0;
            r_x_over <= 1'b0;
            r_y      <= w_y_close;
            r_y_over <= w_y_over_close;
          end
          if (w_vs_fall) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x_over <= 1'b0;
            r_y_over <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_data   = r_pix_data;
  assign bus.sof        = r_sof;
  assign bus.eol        = r_eol;
  assign bus.frame_done = r_frame_done;
  assign bus.line_err   = r_line_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.locked     = r_locked;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_video_capture.sv
// tb/tb_video_capture.sv - directed self-checking bench for video_capture
module tb_video_capture;
  localparam int HD = 32;
  localparam int VD = 24;

  logic pixel_clk = 1'b0;
  logic pixel_rst = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  video_capture_if #(.HDISP(HD), .VDISP(VD)) bus();

  video_capture #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // per-scenario tallies gathered while driving
  int cnt_valid, cnt_sof, cnt_eol, cnt_fd, cnt_le, cnt_fe;
  int bad_data, bad_coord, bad_sof, bad_eol;
  logic [23:0] prev_rgb = '0;

  task automatic clr();
    cnt_valid = 0; cnt_sof = 0; cnt_eol = 0; cnt_fd = 0; cnt_le = 0; cnt_fe = 0;
    bad_data = 0; bad_coord = 0; bad_sof = 0; bad_eol = 0;
  endtask

  // one input cycle; outputs sampled 1ns after the edge reflect the previous call's input
  task automatic drive(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    bus.HS = hs; bus.VS = vs; bus.BLANK = blank; bus.RGB = rgb;
    @(posedge pixel_clk);
    #1;
    if (bus.pix_valid === 1'b1) begin
      cnt_valid++;
      if (bus.pix_data !== prev_rgb) bad_data++;
      if ({3'b000, bus.pix_x} !== bus.pix_data[7:0] || {3'b000, bus.pix_y} !== bus.pix_data[15:8]) bad_coord++;
      if (bus.sof === 1'b1) begin
        cnt_sof++;
        if (bus.pix_x != 0 || bus.pix_y != 0) bad_sof++;
      end
      if (bus.eol === 1'b1) begin
        cnt_eol++;
        if (bus.pix_x != 5'(HD - 1)) bad_eol++;
      end
    end else begin
      if (bus.sof !== 1'b0) bad_sof++;
      if (bus.eol !== 1'b0) bad_eol++;
    end
    if (bus.frame_done === 1'b1) cnt_fd++;
    if (bus.line_err === 1'b1) cnt_le++;
    if (bus.frame_err === 1'b1) cnt_fe++;
    prev_rgb = rgb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic vs_pulse();
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    idle(4);
  endtask

  // RGB carries {A5, line, column} so each emitted pixel's tag can be cross-checked
  task automatic gen_lines(input int n, input int first, input int short_idx, input int short_len);
    for (int l = 0; l < n; l++) begin
      int w;
      w = (first + l == short_idx) ? short_len : HD;
      for (int p = 0; p < w; p++) drive(1'b1, 1'b1, 1'b1, {8'hA5, 8'(first + l), 8'(p)});
      for (int k = 0; k < 6; k++) drive((k == 2 || k == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, 24'h0);
    end
  endtask

  task automatic gen_frame(input int n, input int short_idx, input int short_len);
    idle(3);
    gen_lines(n, 0, short_idx, short_len);
    idle(2);
  endtask

  task automatic do_reset();
    pixel_rst = 1'b1;
    idle(3);
    pixel_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    bus.HS = 1'b1; bus.VS = 1'b1; bus.BLANK = 1'b0; bus.RGB = 24'h0;
    do_reset();
    n_checks++;
    if ({bus.pix_valid, bus.sof, bus.eol, bus.frame_done, bus.line_err, bus.frame_err, bus.locked} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
        {bus.pix_valid, bus.sof, bus.eol, bus.frame_done, bus.line_err, bus.frame_err, bus.locked});
    end
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.pix_data} !== '0) begin
      n_fail++; $display("FAIL reset_pix: got x=%0d y=%0d d=%h expected 0", bus.pix_x, bus.pix_y, bus.pix_data);
    end
    n_checks++;
    if (bus.frame_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.frame_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_nominal();
    clr();
    gen_lines(5, 0, -1, 0);
    n_checks++;
    if (cnt_valid != 0) begin n_fail++; $display("FAIL search_no_pix: got %0d expected 0", cnt_valid); end
    clr();
    vs_pulse();
    gen_frame(VD, -1, 0);
    vs_pulse();
    gen_frame(VD, -1, 0);
    vs_pulse();
    n_checks++;
    if (cnt_valid != 2 * HD * VD) begin n_fail++; $display("FAIL nom_valid: got %0d expected %0d", cnt_valid, 2 * HD * VD); end
    n_checks++;
    if (cnt_fd != 2) begin n_fail++; $display("FAIL nom_frame_done: got %0d expected 2", cnt_fd); end
    n_checks++;
    if (bus.frame_cnt !== 16'd2) begin n_fail++; $display("FAIL nom_frame_cnt: got %0d expected 2", bus.frame_cnt); end
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL nom_locked: got %b expected 1", bus.locked); end
    n_checks++;
    if (bus.err_cnt !== 16'd0 || cnt_le != 0 || cnt_fe != 0) begin
      n_fail++; $display("FAIL nom_errors: got err_cnt=%0d le=%0d fe=%0d expected 0", bus.err_cnt, cnt_le, cnt_fe);
    end
    n_checks++;
    if (bad_data != 0) begin n_fail++; $display("FAIL nom_data_latency: got %0d bad expected 0", bad_data); end
    n_checks++;
    if (bad_coord != 0) begin n_fail++; $display("FAIL nom_coord: got %0d bad expected 0", bad_coord); end
  endtask

  task automatic test_short_line();
    clr();
    idle(3);
    gen_lines(6, 0, 5, HD - 1);
    n_checks++;
    if (cnt_le != 1) begin n_fail++; $display("FAIL short_line_err: got %0d expected 1", cnt_le); end
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL short_locked_drop: got %b expected 0", bus.locked); end
    n_checks++;
    if (bus.err_cnt !== 16'd1) begin n_fail++; $display("FAIL short_err_cnt: got %0d expected 1", bus.err_cnt); end
    gen_lines(VD - 6, 6, -1, 0);
    idle(2);
    vs_pulse();
    n_checks++;
    if (cnt_valid != HD * VD - 1) begin n_fail++; $display("FAIL short_valid: got %0d expected %0d", cnt_valid, HD * VD - 1); end
    n_checks++;
    if (bad_coord != 0 || bad_data != 0) begin
      n_fail++; $display("FAIL short_coord: got coord=%0d data=%0d bad expected 0", bad_coord, bad_data);
    end
    n_checks++;
    if (bus.locked !== 1'b1 || cnt_fd != 1) begin
      n_fail++; $display("FAIL short_relock: got locked=%b fd=%0d expected 1/1", bus.locked, cnt_fd);
    end
    n_checks++;
    if (bus.frame_cnt !== 16'd3) begin n_fail++; $display("FAIL short_frame_cnt: got %0d expected 3", bus.frame_cnt); end
  endtask

  task automatic test_long_frame();
    do_reset();
    clr();
    vs_pulse();
    gen_frame(VD + 1, -1, 0);
    vs_pulse();
    n_checks++;
    if (cnt_valid != HD * VD) begin n_fail++; $display("FAIL long_valid: got %0d expected %0d", cnt_valid, HD * VD); end
    n_checks++;
    if (cnt_fe != 1 || cnt_fd != 0) begin
      n_fail++; $display("FAIL long_pulses: got fe=%0d fd=%0d expected 1/0", cnt_fe, cnt_fd);
    end
    n_checks++;
    if (bus.err_cnt !== 16'd1 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL long_status: got err_cnt=%0d locked=%b expected 1/0", bus.err_cnt, bus.locked);
    end
  endtask

  task automatic test_simultaneous();
    clr();
    idle(3);
    gen_lines(VD - 1, 0, -1, 0);
    for (int p = 0; p < HD; p++) drive(1'b1, 1'b1, 1'b1, {8'hA5, 8'(VD - 1), 8'(p)});
    // last line's BLANK fall coincides with the VS fall
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    idle(4);
    n_checks++;
    if (cnt_fd != 1 || cnt_le != 0 || cnt_fe != 0) begin
      n_fail++; $display("FAIL simul_pulses: got fd=%0d le=%0d fe=%0d expected 1/0/0", cnt_fd, cnt_le, cnt_fe);
    end
    n_checks++;
    if (bus.frame_cnt !== 16'd1 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL simul_status: got frame_cnt=%0d locked=%b expected 1/1", bus.frame_cnt, bus.locked);
    end
  endtask

  task automatic test_markers();
    clr();
    gen_frame(VD, -1, 0);
    vs_pulse();
    n_checks++;
    if (cnt_sof != 1 || bad_sof != 0) begin
      n_fail++; $display("FAIL markers_sof: got count=%0d bad=%0d expected 1/0", cnt_sof, bad_sof);
    end
    n_checks++;
    if (cnt_eol != VD || bad_eol != 0) begin
      n_fail++; $display("FAIL markers_eol: got count=%0d bad=%0d expected %0d/0", cnt_eol, bad_eol, VD);
    end
    n_checks++;
    if (bus.frame_cnt !== 16'd2) begin n_fail++; $display("FAIL markers_frame_cnt: got %0d expected 2", bus.frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clr();
    idle(3);
    gen_lines(10, 0, -1, 0);
    for (int p = 0; p < 5; p++) drive(1'b1, 1'b1, 1'b1, {8'hA5, 8'd10, 8'(p)});
    n_checks++;
    if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", bus.pix_valid); end
    pixel_rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.pix_valid, bus.locked, bus.pix_x, bus.pix_y, bus.pix_data, bus.frame_cnt, bus.err_cnt} !== '0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b locked=%b x=%0d y=%0d d=%h fc=%0d ec=%0d expected all 0",
        bus.pix_valid, bus.locked, bus.pix_x, bus.pix_y, bus.pix_data, bus.frame_cnt, bus.err_cnt);
    end
    idle(3);
    pixel_rst = 1'b0;
    clr();
    for (int p = 5; p < HD; p++) drive(1'b1, 1'b1, 1'b1, {8'hA5, 8'd10, 8'(p)});
    idle(6);
    gen_lines(VD - 11, 11, -1, 0);
    n_checks++;
    if (cnt_valid != 0 || cnt_le != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got valid=%0d le=%0d expected 0/0", cnt_valid, cnt_le);
    end
    vs_pulse();
    gen_frame(VD, -1, 0);
    vs_pulse();
    n_checks++;
    if (cnt_fd != 1 || cnt_valid != HD * VD || bus.frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rstmid_recover: got fd=%0d valid=%0d fc=%0d expected 1/%0d/1",
        cnt_fd, cnt_valid, bus.frame_cnt, HD * VD);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    clr();
    // each pair is a 1-pixel line closing with a 1-line frame: +2 errors (first pair only enters FRAME)
    for (int i = 0; i < 32768; i++) begin
      drive(1'b1, 1'b1, 1'b1, 24'h0);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
    end
    idle(3);
    n_checks++;
    if (bus.err_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", bus.err_cnt); end
    clr();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 24'h0);
      drive(1'b1, 1'b1, 1'b0, 24'h0);
    end
    idle(3);
    n_checks++;
    if (cnt_le != 3) begin n_fail++; $display("FAIL sat_line_err: got %0d expected 3", cnt_le); end
    n_checks++;
    if (bus.err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", bus.err_cnt); end
  endtask

  initial begin
    clr();
    test_reset();
    test_nominal();
    test_short_line();
    test_long_frame();
    test_simultaneous();
    test_markers();
    test_reset_mid_frame();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
